hazard_decoder: RTL
===================

Name: hazard_decoder

Overview:
- Receive-side companion to the hazard-light driver. Samples the three lamp outputs {LLight, MLight, RLight} every clock and recovers the wind mode the driver is signalling.
- Recoverable modes: calm, right-to-left, or left-to-right.
- Reports the mode with a lock indicator, an error pulse and a step pulse. Used for self-check on the board and as a bench monitor.

Parameters:
- LOCK_COUNT, 3, consecutive same-class steps needed to assert lock (>=1).
- TIMEOUT, 8, consecutive unchanged lamp samples that drop lock (>=2).

Ports:
- clk  input  1  system clock, all sampling on rising edge.
- reset  input  1  asynchronous, active-low reset; one clock domain.
- LLight  input  1  left lamp.
- MLight  input  1  middle lamp.
- RLight  input  1  right lamp.
- mode  output  2  00 none, 01 calm, 10 right-to-left, 11 left-to-right; 00 whenever locked=0.
- locked  output  1  mode is valid.
- err  output  1  one-cycle pulse on an illegal lamp code.
- step  output  1  one-cycle pulse for each step matching the locked mode.

Behaviour:
- Lamp code L = {LLight, MLight, RLight}.
  - Legal codes: 101 OUT, 010 MID, 001 RGT, 100 LFT.
  - 000 is IDLE.
  - 011, 110, 111 are ILLEGAL.
- Step class (prev legal code -> current code, prev != current):
  - CALM: 101->010, 010->101.
  - RL: 001->010, 010->100, 100->001.
  - LR: 100->010, 010->001, 001->100.
  - Any other legal->legal change is BREAK.
- Registers:
  - prev[2:0] and prev_v: last legal code, and its valid flag.
  - cand[1:0]: candidate class.
  - cnt: width $clog2(LOCK_COUNT+1), saturating.
  - stall: width $clog2(TIMEOUT+1), saturating.
  - FSM state.
- All outputs are registered and change only on a clk edge or on reset.
- Reset (reset=0, asynchronous): state=EMPTY, prev_v=0, cnt=0, stall=0, cand=00, mode=00, locked=0, err=0, step=0. A reset asserted mid-stream takes effect immediately; the first edge after release treats the input as the first sample.
- FSM states: EMPTY (no prev), ACQUIRE, LOCKED. Per-edge rules, in priority order:
  1. ILLEGAL input: err=1 for one cycle, prev_v=0, cnt=0, stall=0, state=EMPTY, locked=0, mode=00.
  2. IDLE input: prev_v=0, cnt=0, stall=0, state=EMPTY, locked=0, mode=00, no err.
  3. Legal input in EMPTY: prev=L, prev_v=1, state=ACQUIRE, cnt=0.
  4. Legal input equal to prev: stall+1. When stall reaches TIMEOUT: locked=0, mode=00, cnt=0, state=ACQUIRE. In ACQUIRE, cnt is not cleared by stalls below TIMEOUT.
  5. Legal input with a CALM/RL/LR step: prev=L, stall=0.
     - ACQUIRE: if class==cand, cnt+1; otherwise cand=class, cnt=1. When the new cnt reaches LOCK_COUNT: state=LOCKED, locked=1, mode=cand.
     - LOCKED with class==mode: step=1, state stays LOCKED.
     - LOCKED with class!=mode: locked=0, mode=00, state=ACQUIRE, cand=class, cnt=1. With LOCK_COUNT=1 this relocks immediately to the new class instead.
  6. BREAK step: prev=L, stall=0, cnt=0, cand=00, locked=0, mode=00, state=ACQUIRE.
- Latency: with a clean stream whose first legal sample lands at edge k, locked=1 and mode are visible after edge k+LOCK_COUNT. step first pulses after edge k+LOCK_COUNT+1.
- step and err never assert in the same cycle. err never asserts for IDLE.
- Driver mode changes produce a BREAK or mismatched step. The decoder relocks to the new mode within LOCK_COUNT+1 steps.

Test Plan:
1. Reset low, then release; drive 101,010,101,010,101 on successive edges -> locked=1, mode=01 after the 4th edge; step=1 on the 5th edge; err=0 throughout.
2. Drive 001,010,100,001,010 -> mode=10, locked=1 after the 4th edge. Then drive 100,010,001,100 -> locked=0, mode=00 on the 010 edge, relocked with mode=11 on the 2nd 100 edge.
3. Locked on RL, then hold 100 for 8 edges -> locked drops after the 8th repeated sample. Then resume 001,010,100 -> relocks to mode=10 after the 3rd step.
4. Locked on calm, then drive 111 -> err=1 for exactly one cycle, locked=0, mode=00. Then drive 000 -> err stays 0. Then drive 101,010,101,010 -> relock.
5. Mid-stream, locked on LR, pulse reset low asynchronously between edges -> all outputs 0 immediately. After release, lock requires a full LOCK_COUNT steps again.
6. Drive 001 then 101 (BREAK), then 010,101,010 -> no lock after the BREAK; locked=1, mode=01 after the 3rd calm step; err never asserts.

Source files
------------

// File: rtl/hazard_decoder.sv
// hazard_decoder: recovers the wind mode signalled on the three hazard lamps
module hazard_decoder #(
    parameter int LOCK_COUNT = 3,
    parameter int TIMEOUT    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       LLight,
    input  logic       MLight,
    input  logic       RLight,
    output logic [1:0] mode,
    output logic       locked,
    output logic       err,
    output logic       step
);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LC = CW'(LOCK_COUNT);
    localparam logic [SW-1:0] TO = SW'(TIMEOUT);
    typedef enum logic [1:0] {EMPTY, ACQUIRE, LOCKED} state_t;
    state_t state;
    logic [2:0] code, prev;
    logic prev_v, legal, bad;
    logic [1:0] cand, cls;
    logic [CW-1:0] cnt, cnt_nx;
    logic [SW-1:0] stall, stall_nx;
    assign code = {LLight, MLight, RLight};
    // Classify the lamp code and the step from the last legal code
    always_comb begin
        legal = code inside {3'b101, 3'b010, 3'b001, 3'b100};
        bad = !legal && code != 3'b000;
        cls = ({prev, code} inside {6'b101_010, 6'b010_101}) ? 2'b01 :
              ({prev, code} inside {6'b001_010, 6'b010_100, 6'b100_001}) ? 2'b10 :
              ({prev, code} inside {6'b100_010, 6'b010_001, 6'b001_100}) ? 2'b11 : 2'b00;
        stall_nx = (stall == TO) ? stall : stall + 1'b1;
        cnt_nx = (state == ACQUIRE && cls == cand) ? ((cnt == LC) ? cnt : cnt + 1'b1) : CW'(1);
    end
    // Per-edge decode, highest-priority rule first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            prev <= '0;
            prev_v <= 1'b0;
            cand <= '0;
            cnt <= '0;
            stall <= '0;
            mode <= '0;
            locked <= 1'b0;
            err <= 1'b0;
            step <= 1'b0;
        end else begin
            err <= 1'b0;
            step <= 1'b0;
            if (!legal) begin
                err <= bad;
                prev_v <= 1'b0;
                cnt <= '0;
                stall <= '0;
                state <= EMPTY;
                locked <= 1'b0;
                mode <= '0;
            end else if (!prev_v) begin
                prev <= code;
                prev_v <= 1'b1;
                cnt <= '0;
                stall <= '0;
                state <= ACQUIRE;
            end else if (code == prev) begin
                stall <= stall_nx;
                if (stall_nx == TO) begin
                    locked <= 1'b0;
                    mode <= '0;
                    cnt <= '0;
                    state <= ACQUIRE;
                end
            end else if (cls == 2'b00) begin
                prev <= code;
                stall <= '0;
                cnt <= '0;
                cand <= '0;
                locked <= 1'b0;
                mode <= '0;
                state <= ACQUIRE;
            end else if (state == LOCKED && cls == mode) begin
                prev <= code;
                stall <= '0;
                step <= 1'b1;
            end else begin
                prev <= code;
                stall <= '0;
                cand <= cls;
                cnt <= cnt_nx;
                state <= (cnt_nx == LC) ? LOCKED : ACQUIRE;
                locked <= (cnt_nx == LC);
                mode <= (cnt_nx == LC) ? cls : 2'b00;
            end
        end
    end
endmodule
